// File: rtl/com_loader.sv
// Host front end: loads a LEN-prefixed little-endian word frame into shared memory, runs the cores, streams a result window back.
// Optional COM_LOADER_CHECKSUM_EN appends an XOR checksum byte after the result bytes.
module com_loader #(
    parameter logic [15:0] LOAD_BASE = 16'h0000,
    parameter logic [15:0] RES_BASE  = 16'h0000,
    parameter logic [15:0] RES_LEN   = 16'd16,
    parameter logic [1:0]  ST_IDLE   = 2'd0,
    parameter logic [1:0]  ST_LOAD   = 2'd1,
    parameter logic [1:0]  ST_RUN    = 2'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [1:0]  status,
    output logic [15:0] com_addr,
    output logic [15:0] com_data_in,
    output logic        com_wr_en,
    input  logic [15:0] com_data_out,
    input  logic        end_process,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RX_LEN_HI,
        S_RX_LO,
        S_RX_HI,
        S_WRITE,
        S_RUN,
        S_RD_ADDR,
        S_RD_WAIT,
        S_RD_CAP,
        S_TX_LO,
        S_TX_HI,
        S_TX_CSUM,
        S_DONE
    } state_t;

    state_t      state;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [7:0]  word_lo;
    logic [15:0] wr_idx;
    logic [15:0] rd_idx;
    logic [1:0]  run_cnt;
    logic [7:0]  rd_hi;
`ifdef COM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    logic [15:0] wr_next;
    logic [16:0] rd_next;
    logic [15:0] len_rx;

    assign wr_next = wr_idx + 16'd1;
    assign rd_next = {1'b0, rd_idx} + 17'd1;
    assign len_rx  = {rx_data, len_lo};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            status      <= ST_IDLE;
            com_addr    <= 16'h0000;
            com_data_in <= 16'h0000;
            com_wr_en   <= 1'b0;
            tx_valid    <= 1'b0;
            tx_data     <= 8'h00;
            busy        <= 1'b0;
            len_lo      <= 8'h00;
            len         <= 16'h0000;
            word_lo     <= 8'h00;
            wr_idx      <= 16'h0000;
            rd_idx      <= 16'h0000;
            run_cnt     <= 2'd0;
            rd_hi       <= 8'h00;
`ifdef COM_LOADER_CHECKSUM_EN
            csum        <= 8'h00;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        len_lo <= rx_data;
                        status <= ST_LOAD;
                        busy   <= 1'b1;
                        state  <= S_RX_LEN_HI;
                    end
                end
                S_RX_LEN_HI: begin
                    if (rx_valid) begin
                        len    <= len_rx;
                        wr_idx <= 16'h0000;
                        if (len_rx == 16'h0000) begin
                            status  <= ST_RUN;
                            run_cnt <= 2'd0;
                            state   <= S_RUN;
                        end else begin
                            state <= S_RX_LO;
                        end
                    end
                end
                S_RX_LO: begin
                    if (rx_valid) begin
                        word_lo <= rx_data;
                        state   <= S_RX_HI;
                    end
                end
                S_RX_HI: begin
                    // Present the write for the whole WRITE cycle, so the pulse is exactly one cycle wide.
                    if (rx_valid) begin
                        com_wr_en   <= 1'b1;
                        com_addr    <= LOAD_BASE + wr_idx;
                        com_data_in <= {rx_data, word_lo};
                        state       <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    com_wr_en <= 1'b0;
                    wr_idx    <= wr_next;
                    if (wr_next == len) begin
                        status  <= ST_RUN;
                        run_cnt <= 2'd0;
                        state   <= S_RUN;
                    end else begin
                        state <= S_RX_LO;
                    end
                end
                S_RUN: begin
                    // end_process may still be high from the previous job; ignore it briefly.
                    if (run_cnt != 2'd2) begin
                        run_cnt <= run_cnt + 2'd1;
                    end else if (end_process) begin
                        if (RES_LEN == 16'd0) begin
                            status <= ST_IDLE;
                            state  <= S_DONE;
                        end else begin
                            status   <= ST_LOAD;
                            rd_idx   <= 16'h0000;
                            com_addr <= RES_BASE;
`ifdef COM_LOADER_CHECKSUM_EN
                            csum     <= 8'h00;
`endif
                            state    <= S_RD_ADDR;
                        end
                    end
                end
                S_RD_ADDR: state <= S_RD_WAIT;
                S_RD_WAIT: state <= S_RD_CAP;
                S_RD_CAP: begin
                    rd_hi    <= com_data_out[15:8];
                    tx_data  <= com_data_out[7:0];
                    tx_valid <= 1'b1;
                    state    <= S_TX_LO;
                end
                S_TX_LO: begin
                    if (tx_ready) begin
`ifdef COM_LOADER_CHECKSUM_EN
                        csum    <= csum ^ tx_data;
`endif
                        tx_data <= rd_hi;
                        state   <= S_TX_HI;
                    end
                end
                S_TX_HI: begin
                    if (tx_ready) begin
`ifdef COM_LOADER_CHECKSUM_EN
                        csum <= csum ^ tx_data;
`endif
                        if (rd_next < {1'b0, RES_LEN}) begin
                            rd_idx   <= rd_next[15:0];
                            com_addr <= RES_BASE + rd_next[15:0];
                            tx_valid <= 1'b0;
                            state    <= S_RD_ADDR;
                        end else begin
`ifdef COM_LOADER_CHECKSUM_EN
                            tx_data <= csum ^ tx_data;
                            state   <= S_TX_CSUM;
`else
                            tx_valid <= 1'b0;
                            status   <= ST_IDLE;
                            state    <= S_DONE;
`endif
                        end
                    end
                end
`ifdef COM_LOADER_CHECKSUM_EN
                S_TX_CSUM: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        status   <= ST_IDLE;
                        state    <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    com_wr_en <= 1'b0;
                    tx_valid  <= 1'b0;
                    status    <= ST_IDLE;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
